// File: rtl/bist_response_controller_pkg.sv
// Shared definitions for the BIST response controller: FSM state encoding,
// MISR width and the compactor step function.
package bist_response_controller_pkg;

  localparam int MISR_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Team compactor polynomial: rotate left by one, then fold in the chain outputs.
  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] q,
                                                  input logic [MISR_W-1:0] s);
    return s ^ {q[MISR_W-2:0], q[MISR_W-1]};
  endfunction

endpackage

// File: rtl/bist_response_controller_misr.sv
// 7-bit multiple-input signature register with synchronous clear and enable.
module misr7_en
  import bist_response_controller_pkg::*;
(
  input  logic              CK,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              en,
  input  logic [MISR_W-1:0] d,
  output logic [MISR_W-1:0] q
);

  logic [MISR_W-1:0] sig_q;
  logic [MISR_W-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = misr_step(sig_q, d);
    end
  end

  always_ff @(posedge CK or negedge reset_n) begin
    if (!reset_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign q = sig_q;

endmodule

// File: rtl/bist_response_controller.sv
// BIST sequencer and response analyzer: walks init/shift/capture/compare,
// compacts scan-chain outputs into a MISR and reports done/pass.
module bist_response_controller
  import bist_response_controller_pkg::*;
#(
  parameter int          CHAIN_LEN    = 33,
  parameter int          NUM_PATTERNS = 100,
  parameter logic [6:0]  GOLDEN_SIG   = 7'h00
) (
  input  logic       CK,
  input  logic       reset_n,
  input  logic       start,
  input  logic [6:0] scan_outs,
  output logic       bist_en,
  output logic       scan_en,
  output logic       tpg_reset,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] signature,
  output logic [2:0] dbg_state
);

  localparam int SC_W = $clog2(CHAIN_LEN + 1);
  localparam int PC_W = $clog2(NUM_PATTERNS + 1);

  // Tester handshake: start is a request accepted only in IDLE or DONE;
  // done stays high until the next accepted start, and pass is valid while done.
  state_t            state_q, state_d;
  logic [SC_W-1:0]   shift_cnt_q, shift_cnt_d;
  logic [PC_W-1:0]   pat_cnt_q, pat_cnt_d;
  logic              pass_q, pass_d;
  logic              last_shift;
  logic              misr_en;
  logic              misr_clr;

  assign last_shift = (shift_cnt_q == SC_W'(CHAIN_LEN - 1));

  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    pat_cnt_d   = pat_cnt_q;
    pass_d      = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_INIT;
          pass_d  = 1'b0;
        end
      end
      ST_INIT: begin
        shift_cnt_d = '0;
        pat_cnt_d   = '0;
        state_d     = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last_shift) begin
          shift_cnt_d = '0;
          state_d     = (pat_cnt_q < PC_W'(NUM_PATTERNS)) ? ST_CAPTURE : ST_COMPARE;
        end else begin
          shift_cnt_d = shift_cnt_q + SC_W'(1);
        end
      end
      ST_CAPTURE: begin
        pat_cnt_d   = pat_cnt_q + PC_W'(1);
        shift_cnt_d = '0;
        state_d     = ST_SHIFT;
      end
      ST_COMPARE: begin
        pass_d  = (signature == GOLDEN_SIG);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_INIT;
          pass_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      shift_cnt_q <= '0;
      pat_cnt_q   <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      pat_cnt_q   <= pat_cnt_d;
      pass_q      <= pass_d;
    end
  end

  // Outputs decode straight from the state register so the TPG clock gate sees no glitches.
  assign bist_en   = (state_q == ST_INIT) || (state_q == ST_SHIFT);
  assign scan_en   = (state_q == ST_SHIFT);
  assign tpg_reset = (state_q == ST_INIT);
  assign busy      = (state_q == ST_INIT) || (state_q == ST_SHIFT) ||
                     (state_q == ST_CAPTURE) || (state_q == ST_COMPARE);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign dbg_state = state_q;

  // The first shift pass only loads the chains; its unload data is unknown.
  assign misr_en  = (state_q == ST_SHIFT) && (pat_cnt_q != '0);
  assign misr_clr = (state_q == ST_INIT);

  misr7_en u_misr (
    .CK      (CK),
    .reset_n (reset_n),
    .clr     (misr_clr),
    .en      (misr_en),
    .d       (scan_outs),
    .q       (signature)
  );

endmodule
